// File: rtl/philo_pkg.sv
// Shared types for the philosopher ring: seat state encoding and the ring
// neighbour index helper.
package philo_pkg;

  typedef enum logic [1:0] {
    THINKING = 2'd0,
    READING  = 2'd1,
    EATING   = 2'd2,
    HUNGRY   = 2'd3
  } state_t;

  // Seat index at distance off around a ring of n seats (off in 0..n-1).
  function automatic int nbr(input int i, input int n, input int off);
    return (i + off) % n;
  endfunction

endpackage

// File: rtl/philo_cell.sv
// One philosopher seat: state register, eat pulse, and the optional
// starvation counter (built only when PHILO_STARVE_MON_EN is defined).
module philo_cell
  import philo_pkg::*;
#(
  parameter state_t INIT_ST      = THINKING,
  parameter int     STARVE_LIMIT = 15
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   coin,
  input  state_t left,
  input  state_t right,
  output state_t st,
  output logic   eat_pulse,
  output logic   eat_next,
  output logic   starve
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("philo_cell: STARVE_LIMIT out of range 1..255");
  end

  state_t st_d, st_q;
  logic   eat_pulse_q;

  always_comb begin
    st_d = st_q;
    case (st_q)
      READING:  if (left == THINKING) st_d = THINKING;
      THINKING: st_d = !coin ? HUNGRY : (right == READING) ? READING : THINKING;
      EATING:   if (coin) st_d = THINKING;
      HUNGRY:   if (left != EATING && right != HUNGRY && right != EATING) st_d = EATING;
      default:  st_d = st_q;
    endcase
  end

  // Exported so the ring can count meals in the same cycle the pulse shows.
  assign eat_next = (st_q == HUNGRY) && (st_d == EATING);

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q        <= INIT_ST;
      eat_pulse_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      eat_pulse_q <= eat_next;
    end
  end

  assign st        = st_q;
  assign eat_pulse = eat_pulse_q;

`ifdef PHILO_STARVE_MON_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] cnt_d, cnt_q;
  logic       starve_d, starve_q;

  always_comb begin
    cnt_d    = 8'd0;
    if (st_d == HUNGRY) cnt_d = (cnt_q >= LIMIT) ? LIMIT : cnt_q + 8'd1;
    starve_d = (cnt_d == LIMIT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= 8'd0;
      starve_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  assign starve = starve_q;
`else
  assign starve = 1'b0;
`endif

endmodule

// File: rtl/philo_ring.sv
// N-seat philosopher ring with meal accounting and sticky adjacent-eat /
// deadlock flags; per-seat starvation monitor under PHILO_STARVE_MON_EN.
module philo_ring
  import philo_pkg::*;
#(
  parameter int N            = 8,
  parameter int INIT_READER  = 0,
  parameter int STARVE_LIMIT = 15,
  parameter int MW           = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    coin,
  output logic [2*N-1:0]  st,
  output logic [N-1:0]    eat_pulse,
  output logic [MW-1:0]   meals,
  output logic            adj_eat,
  output logic            deadlock,
  output logic [N-1:0]    starve
);

  if (N < 3 || N > 64) begin : g_bad_n
    $error("philo_ring: N out of range 3..64");
  end

  state_t         seat [N];
  logic [N-1:0]   eat_next;

  for (genvar i = 0; i < N; i++) begin : g_seat
    localparam state_t INIT_ST = (i == INIT_READER) ? READING : THINKING;
    localparam int     L       = nbr(i, N, 1);
    localparam int     R       = nbr(i, N, N - 1);

    philo_cell #(
      .INIT_ST      (INIT_ST),
      .STARVE_LIMIT (STARVE_LIMIT)
    ) u_cell (
      .clock     (clock),
      .reset     (reset),
      .coin      (coin[i]),
      .left      (seat[L]),
      .right     (seat[R]),
      .st        (seat[i]),
      .eat_pulse (eat_pulse[i]),
      .eat_next  (eat_next[i]),
      .starve    (starve[i])
    );

    assign st[2*i+1:2*i] = seat[i];
  end

  localparam logic [MW+6:0] MEAL_MAX = {7'd0, {MW{1'b1}}};

  logic [6:0]    pc;
  logic [MW+6:0] sum;
  logic [MW-1:0] meals_d, meals_q;
  logic          adj_c, dl_c;
  logic          adj_d, adj_q, dl_d, dl_q;

  always_comb begin
    pc    = 7'd0;
    adj_c = 1'b0;
    dl_c  = 1'b1;
    for (int i = 0; i < N; i++) begin
      pc    = pc + 7'(eat_next[i]);
      adj_c = adj_c | (seat[i] == EATING && seat[nbr(i, N, 1)] == EATING);
      dl_c  = dl_c & (seat[i] == HUNGRY);
    end
    sum     = {7'd0, meals_q} + {{MW{1'b0}}, pc};
    meals_d = (sum > MEAL_MAX) ? {MW{1'b1}} : sum[MW-1:0];
    // Flags look at the registered states, so they trail them by a cycle.
    adj_d   = adj_q | adj_c;
    dl_d    = dl_q | dl_c;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meals_q <= '0;
      adj_q   <= 1'b0;
      dl_q    <= 1'b0;
    end else begin
      meals_q <= meals_d;
      adj_q   <= adj_d;
      dl_q    <= dl_d;
    end
  end

  assign meals    = meals_q;
  assign adj_eat  = adj_q;
  assign deadlock = dl_q;

endmodule

// File: tb/tb_philo_ring.sv
// Directed + model-checked random bench for philo_ring (starve checks follow
// PHILO_STARVE_MON_EN).
module tb_philo_ring;

  localparam logic [1:0] T = 2'd0, R = 2'd1, E = 2'd2, H = 2'd3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // ua: N=4 reader at 2; ub: N=4 reader at 0, limit 3
  logic [3:0]  coin_a, coin_b;
  logic [7:0]  st_a, st_b;
  logic [3:0]  ep_a, ep_b, sv_a, sv_b;
  logic [15:0] ml_a, ml_b;
  logic        adj_a, adj_b, dl_a, dl_b;

  // model-checked: k=0 N=5, k=1 N=64, k=2 N=4 MW=2 limit 1
  logic [4:0]   coin5, ep5, sv5;
  logic [9:0]   st5;
  logic [15:0]  ml5;
  logic         adj5, dl5;
  logic [63:0]  coin64, ep64, sv64;
  logic [127:0] st64;
  logic [15:0]  ml64;
  logic         adj64, dl64;
  logic [3:0]   coin_s, ep_s, sv_s;
  logic [7:0]   st_s;
  logic [1:0]   ml_s;
  logic         adj_s, dl_s;

  philo_ring #(.N(4), .INIT_READER(2)) ua (
    .clock(clock), .reset(reset), .coin(coin_a), .st(st_a), .eat_pulse(ep_a),
    .meals(ml_a), .adj_eat(adj_a), .deadlock(dl_a), .starve(sv_a));
  philo_ring #(.N(4), .INIT_READER(0), .STARVE_LIMIT(3)) ub (
    .clock(clock), .reset(reset), .coin(coin_b), .st(st_b), .eat_pulse(ep_b),
    .meals(ml_b), .adj_eat(adj_b), .deadlock(dl_b), .starve(sv_b));
  philo_ring #(.N(5), .INIT_READER(4)) u5 (
    .clock(clock), .reset(reset), .coin(coin5), .st(st5), .eat_pulse(ep5),
    .meals(ml5), .adj_eat(adj5), .deadlock(dl5), .starve(sv5));
  philo_ring #(.N(64), .INIT_READER(37), .STARVE_LIMIT(5)) u64 (
    .clock(clock), .reset(reset), .coin(coin64), .st(st64), .eat_pulse(ep64),
    .meals(ml64), .adj_eat(adj64), .deadlock(dl64), .starve(sv64));
  philo_ring #(.N(4), .INIT_READER(1), .STARVE_LIMIT(1), .MW(2)) us (
    .clock(clock), .reset(reset), .coin(coin_s), .st(st_s), .eat_pulse(ep_s),
    .meals(ml_s), .adj_eat(adj_s), .deadlock(dl_s), .starve(sv_s));

  // reference model
  int          m_n   [3] = '{5, 64, 4};
  int          m_init[3] = '{4, 37, 1};
  int          m_lim [3] = '{15, 5, 1};
  int          m_max [3] = '{65535, 65535, 3};
  logic [1:0]  m_st  [3][64];
  int          m_cnt [3][64];
  logic [63:0] m_pulse[3], m_starve[3];
  int          m_meals[3];
  logic        m_adj[3], m_dl[3];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      if (bad <= 40) $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 64; i++) begin
        m_st[k][i]  = (i == m_init[k]) ? R : T;
        m_cnt[k][i] = 0;
      end
      m_pulse[k] = '0; m_starve[k] = '0; m_meals[k] = 0;
      m_adj[k] = 1'b0; m_dl[k] = 1'b1 & 1'b0;
    end
  endtask

  task automatic m_step(input int k, input logic [63:0] c);
    logic [1:0] nx [64];
    logic [1:0] l, r;
    int n, pc;
    logic adj, dl;
    n = m_n[k]; pc = 0; adj = 1'b0; dl = 1'b1;
    for (int i = 0; i < n; i++) begin
      l = m_st[k][(i + 1) % n];
      r = m_st[k][(i + n - 1) % n];
      nx[i] = m_st[k][i];
      case (m_st[k][i])
        R: if (l == T) nx[i] = T;
        T: nx[i] = (c[i] && r == R) ? R : (c[i] ? T : H);
        E: if (c[i]) nx[i] = T;
        default: if (l != E && r != H && r != E) nx[i] = E;
      endcase
      adj = adj | (m_st[k][i] == E && l == E);
      dl  = dl & (m_st[k][i] == H);
    end
    m_pulse[k] = '0; m_starve[k] = '0;
    for (int i = 0; i < n; i++) begin
      if (m_st[k][i] == H && nx[i] == E) begin m_pulse[k][i] = 1'b1; pc++; end
      m_cnt[k][i] = (nx[i] == H) ? ((m_cnt[k][i] + 1 > m_lim[k]) ? m_lim[k] : m_cnt[k][i] + 1) : 0;
      m_starve[k][i] = (m_cnt[k][i] == m_lim[k]);
      m_st[k][i] = nx[i];
    end
    m_meals[k] = (m_meals[k] + pc > m_max[k]) ? m_max[k] : m_meals[k] + pc;
    m_adj[k] = m_adj[k] | adj;
    m_dl[k]  = m_dl[k] | dl;
  endtask

  function automatic logic [127:0] m_pack(input int k);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < m_n[k]; i++) v[2*i +: 2] = m_st[k][i];
    return v;
  endfunction

  function automatic logic [63:0] exp_starve(input logic [63:0] v);
`ifdef PHILO_STARVE_MON_EN
    return v;
`else
    return 64'(v & 64'd0);
`endif
  endfunction

  task automatic step();
    if (reset) m_reset();
    else begin
      m_step(0, 64'(coin5)); m_step(1, coin64); m_step(2, 64'(coin_s));
    end
    @(posedge clock); #1;
  endtask

  task automatic chk_models();
    chk("n5_st", st5, m_pack(0));     chk("n5_pulse", ep5, m_pulse[0]);
    chk("n5_meals", ml5, m_meals[0]); chk("n5_adj", adj5, m_adj[0]);
    chk("n5_dl", dl5, m_dl[0]);       chk("n5_starve", sv5, exp_starve(m_starve[0]));
    chk("n64_st", st64, m_pack(1));   chk("n64_pulse", ep64, m_pulse[1]);
    chk("n64_meals", ml64, m_meals[1]); chk("n64_adj", adj64, m_adj[1]);
    chk("n64_dl", dl64, m_dl[1]);     chk("n64_starve", sv64, exp_starve(m_starve[1]));
    chk("sat_st", st_s, m_pack(2));   chk("sat_pulse", ep_s, m_pulse[2]);
    chk("sat_meals", ml_s, m_meals[2]); chk("sat_dl", dl_s, m_dl[2]);
    chk("sat_starve", sv_s, exp_starve(m_starve[2]));
  endtask

  initial begin
    coin_a = '0; coin_b = '0; coin5 = '0; coin64 = '0; coin_s = '0;
    reset = 1'b1;
    step();
    chk("a_rst_st", st_a, 8'h10);  chk("a_rst_pulse", ep_a, 4'h0);
    chk("a_rst_meals", ml_a, 16'd0); chk("a_rst_adj", adj_a, 1'b0);
    chk("a_rst_dl", dl_a, 1'b0);   chk("a_rst_starve", sv_a, 4'h0);
    chk("b_rst_st", st_b, 8'h01);
    chk_models();

    reset = 1'b0;
    coin_a = 4'b0111; step();
    chk("b1_st", st_b, 8'hFC); chk("b1_pulse", ep_b, 4'h0); chk("b1_meals", ml_b, 16'd0);
    chk("b1_starve", sv_b, exp_starve(64'h0));
    chk("a1_st", st_a, 8'hC0);

    coin_a = 4'b1111; step();
    chk("b2_st", st_b, 8'hFB); chk("b2_pulse", ep_b, 4'b0010); chk("b2_meals", ml_b, 16'd1);
    chk("b2_starve", sv_b, exp_starve(64'h0));
    chk("a2_st", st_a, 8'h80); chk("a2_pulse", ep_a, 4'b1000); chk("a2_meals", ml_a, 16'd1);

    coin_b = 4'b0010; step();
    chk("b3_st", st_b, 8'hF3); chk("b3_pulse", ep_b, 4'h0); chk("b3_meals", ml_b, 16'd1);
    chk("b3_starve", sv_b, exp_starve(64'hC));
    chk("a3_st", st_a, 8'h00); chk("a3_pulse", ep_a, 4'h0);

    coin_b = 4'b0000; coin_a = 4'b0000; step();
    chk("b4_st", st_b, 8'hEF); chk("b4_pulse", ep_b, 4'b0100); chk("b4_meals", ml_b, 16'd2);
    chk("b4_starve", sv_b, exp_starve(64'h9));
    chk("a4_st", st_a, 8'hFF); chk("a4_dl", dl_a, 1'b0);

    step();
    chk("b5_st", st_b, 8'hEF); chk("b5_pulse", ep_b, 4'h0); chk("b5_meals", ml_b, 16'd2);
    chk("b5_starve", sv_b, exp_starve(64'h9)); chk("b5_adj", adj_b, 1'b0);
    chk("b5_dl", dl_b, 1'b0);
    chk("a5_st", st_a, 8'hFF); chk("a5_dl", dl_a, 1'b1);

    // mid-run reset with seat2 of ub eating and ua deadlocked
    reset = 1'b1; step();
    chk("b_mrst_st", st_b, 8'h01); chk("b_mrst_pulse", ep_b, 4'h0);
    chk("b_mrst_meals", ml_b, 16'd0); chk("b_mrst_starve", sv_b, 4'h0);
    chk("a_mrst_st", st_a, 8'h10); chk("a_mrst_meals", ml_a, 16'd0);
    chk("a_mrst_dl", dl_a, 1'b0);
    chk_models();

    reset = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      coin5  = 5'($urandom);
      coin64 = {$urandom, $urandom};
      coin_s = 4'($urandom);
      reset  = (cyc % 2000 == 1999);
      step();
      chk_models();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
